// File: rtl/usb_status_pkg.sv
// usb_status_pkg
// Shared definitions for the status-stream UART transmitter: the FSM state
// enum, the bit-period helper and the frame length.
// Build option: USB_STATUS_UART_PARITY_EN adds an even-parity bit (8E1).
// No ports (package).

package usb_status_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
`ifdef USB_STATUS_UART_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP  = 3'd5
    } state_t;

`ifdef USB_STATUS_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Rounded clocks per bit so the baud error stays within half a clock.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/usb_status_uart_tx_baud_tick.sv
// uart_baud_tick
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the last count so
// the FSM advances exactly once per bit time.
// Ports:
//   clk48    in  1  system clock
//   rst      in  1  asynchronous active-high reset
//   restart  in  1  synchronous clear; count is 0 on the following cycle
//   tick     out 1  high while count == CLKS_PER_BIT-1

module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 417
) (
    input  logic clk48,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TC);

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/usb_status_uart_tx.sv
// usb_status_uart_tx
// Pulls bytes from the status annunciator over its level-request handshake
// and sends each one as asynchronous serial (8N1, or 8E1 when
// USB_STATUS_UART_PARITY_EN is defined).
// Ports:
//   clk48  in  1  system clock
//   rst    in  1  asynchronous active-high reset
//   en     in  1  stream enable; gates only the start of a new request
//   inc    out 1  byte request to the annunciator (level)
//   din    in  8  byte from the annunciator
//   din_v  in  1  byte valid from the annunciator
//   tx     out 1  serial line, idle high
//   busy   out 1  high from byte capture to end of stop bit
//
// state  | meaning
// IDLE   | line idle, inc low; at least one cycle so annunciator clears inhibit
// REQ    | inc high, waiting for din_v (first cycle ignores stale din_v)
// START  | start bit (tx low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit (tx high), then back to IDLE

module usb_status_uart_tx
    import usb_status_pkg::*;
#(
    parameter int CLK_HZ       = 48000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic       clk48,
    input  logic       rst,
    input  logic       en,
    output logic       inc,
    input  logic [7:0] din,
    input  logic       din_v,
    output logic       tx,
    output logic       busy
);

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       req_armed;
    logic       par_bit;
    logic       tick;
    logic       restart;

    // Holding the counter clear outside the timed states makes every timed
    // state start from count 0; inside them the counter self-wraps on tick,
    // which coincides with every state change.
    assign restart = (state == ST_IDLE) || (state == ST_REQ);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk48   (clk48),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            inc       <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            shreg     <= '0;
            bit_idx   <= '0;
            req_armed <= 1'b0;
            par_bit   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    inc <= 1'b0;
                    tx  <= 1'b1;
                    if (en) begin
                        state     <= ST_REQ;
                        inc       <= 1'b1;
                        req_armed <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // The annunciator needs a cycle to see inc before its
                    // dout_v means anything.
                    if (!req_armed) begin
                        req_armed <= 1'b1;
                    end else if (din_v) begin
                        shreg   <= din;
                        par_bit <= ^din;
                        state   <= ST_START;
                        inc     <= 1'b0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
`ifdef USB_STATUS_UART_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= par_bit;
`else
                            state <= ST_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end
                end
`ifdef USB_STATUS_UART_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        tx    <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    inc   <= 1'b0;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_status_uart_tx.sv
// tb_usb_status_uart_tx
// Directed + randomized bench: an annunciator model answers inc with queued
// bytes (optionally stalling), and each frame on tx is compared cycle by
// cycle against the bit pattern expected for the byte.

module tb_usb_status_uart_tx;

    localparam int CLK_HZ = 48000000;
    localparam int BAUD   = 115200;
    localparam int CPB    = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef USB_STATUS_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk48 = 1'b0;
    logic       rst;
    logic       en;
    logic       inc;
    logic [7:0] din;
    logic       din_v;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] byte_q [0:63];
    int         stall_q[0:63];
    int         wr = 0;
    int         stale_gen = 0;

    always #10 clk48 = ~clk48;

    usb_status_uart_tx dut (
        .clk48 (clk48),
        .rst   (rst),
        .en    (en),
        .inc   (inc),
        .din   (din),
        .din_v (din_v),
        .tx    (tx),
        .busy  (busy)
    );

    // Annunciator model: answers one cycle after it sees inc, one byte per
    // request, holding a stale valid after reset until it sees inc.
    initial begin : annunciator
        int rd;
        int held;
        bit given;
        bit inc_prev;
        int stale_seen;
        rd = 0; held = 0; given = 0; inc_prev = 0; stale_seen = 0;
        din = 8'h00;
        din_v = 1'b0;
        forever begin
            @(negedge clk48);
            if (stale_gen != stale_seen) begin
                din   = 8'hFF;
                din_v = 1'b1;
                if (inc === 1'b1) stale_seen = stale_gen;
            end else if (inc === 1'b1 && inc_prev && !given && rd != wr) begin
                if (held < stall_q[rd]) begin
                    held++;
                    din_v = 1'b0;
                end else begin
                    din   = byte_q[rd];
                    din_v = 1'b1;
                    rd++;
                    given = 1;
                    held  = 0;
                end
            end else begin
                din_v = 1'b0;
            end
            if (inc !== 1'b1) given = 0;
            inc_prev = (inc === 1'b1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input int stall);
        byte_q[wr]  = b;
        stall_q[wr] = stall;
        wr++;
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (NB == 11 && b == 9) return ^d;
        return 1'b1;
    endfunction

    // Waits for a start bit, then checks every cycle of the frame and the
    // idle cycle that follows. Ends on the negedge of that idle cycle.
    task automatic run_frame(input logic [7:0] d, input bit check_gap, input int drop_en_at);
        int waits;
        int errs;
        int berrs;
        int first;
        waits = 0; errs = 0; berrs = 0; first = -1;
        while (tx !== 1'b0 && waits < 20000) begin
            @(negedge clk48);
            waits++;
        end
        chk($sformatf("start_%02h", d), {31'd0, tx}, 32'd0);
        if (tx !== 1'b0) return;
        if (check_gap) chk($sformatf("gap_%02h", d), waits, 32'd3);
        chk($sformatf("inc_low_at_start_%02h", d), {31'd0, inc}, 32'd0);
        for (int c = 0; c < NB * CPB; c++) begin
            if (c == drop_en_at) en = 1'b0;
            if (tx !== exp_bit(d, c / CPB)) begin
                if (errs == 0) first = c;
                errs++;
            end
            if (busy !== 1'b1) berrs++;
            @(negedge clk48);
        end
        chk($sformatf("frame_%02h_first_bad_cycle_%0d", d, first), errs, 32'd0);
        chk($sformatf("busy_in_frame_%02h", d), berrs, 32'd0);
        chk($sformatf("busy_after_%02h", d), {31'd0, busy}, 32'd0);
        chk($sformatf("tx_idle_after_%02h", d), {31'd0, tx}, 32'd1);
    endtask

    initial begin : main
        logic [7:0] rb [0:5];
        logic [7:0] b;
        int cnt;
        int w;
        int viol;

        rst = 1'b1;
        en  = 1'b0;
        repeat (5) @(negedge clk48);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_inc", {31'd0, inc}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Stale din_v=1/din=FF through release; 0x41 on the second REQ cycle.
        stale_gen = 1;
        push(8'h41, 0);
        en = 1'b1;
        @(negedge clk48);
        rst = 1'b0;
        @(negedge clk48);
        chk("req_inc_high", {31'd0, inc}, 32'd1);
        chk("req1_no_capture", {31'd0, busy}, 32'd0);
        @(negedge clk48);
        chk("req2_no_capture_yet", {31'd0, busy}, 32'd0);
        run_frame(8'h41, 1'b0, -1);

        // Back-to-back bytes, then a request stalled for 5 cycles.
        push(8'h1B, 0);
        push(8'h5B, 0);
        push(8'h48, 0);
        push(8'h30, 5);
        run_frame(8'h1B, 1'b0, -1);
        run_frame(8'h5B, 1'b1, -1);
        run_frame(8'h48, 1'b1, -1);

        w = 0;
        while (inc !== 1'b1 && w < 100) begin
            @(negedge clk48);
            w++;
        end
        cnt = 0;
        while (inc === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk48);
        end
        chk("wrap_inc_high_cycles", cnt, 32'd7);
        run_frame(8'h30, 1'b0, -1);
        viol = 0;
        repeat (2000) begin
            @(negedge clk48);
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("no_repeat_after_wrap", viol, 32'd0);
        chk("req_waiting", {31'd0, inc}, 32'd1);

        // Randomized bytes including the parity corner cases.
        rb[0] = 8'h07;
        rb[1] = 8'h03;
        for (int i = 2; i < 6; i++) rb[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) push(rb[i], 0);
        for (int i = 0; i < 6; i++) run_frame(rb[i], (i != 0), -1);

        // Drop en mid-DATA: frame completes, no further request until en returns.
        push(8'h55, 0);
        run_frame(8'h55, 1'b0, CPB * 3 + 10);
        b = 8'($urandom_range(0, 255));
        push(b, 0);
        viol = 0;
        repeat (100) begin
            @(negedge clk48);
            if (inc !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) viol++;
        end
        chk("en_gated", viol, 32'd0);
        en = 1'b1;
        run_frame(b, 1'b0, -1);

        // Reset during data bit 3 (chosen as 0 so tx is low when reset hits).
        b = 8'($urandom_range(0, 255)) & 8'hF7;
        push(b, 0);
        w = 0;
        while (tx !== 1'b0 && w < 20000) begin
            @(negedge clk48);
            w++;
        end
        chk("rst_frame_started", {31'd0, tx}, 32'd0);
        repeat (CPB * 4 + 200) @(negedge clk48);
        chk("rst_pre_tx_low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_tx", {31'd0, tx}, 32'd1);
        chk("rst_async_inc", {31'd0, inc}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk48);
        rst = 1'b0;
        b = 8'($urandom_range(0, 255));
        push(b, 0);
        run_frame(b, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
